// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared definitions for the 4-way round-robin mux arbiter.
//   - arb_state_e : arbiter FSM states
//   - N_REQ       : number of requesters
//   - rr_pick     : rotating priority encoder, first set request at or after ptr
package mux4_rr_arbiter_pkg;

   localparam int unsigned N_REQ = 4;

   typedef enum logic {
      StIdle  = 1'b0,
      StGrant = 1'b1
   } arb_state_e;

   // Scan ptr, ptr+1, ... (mod 4) and return the first requester found.
   // Returns ptr when nothing is requesting; callers only use it when req != 0.
   function automatic logic [1:0] rr_pick(input logic [N_REQ-1:0] req,
                                          input logic [1:0]       ptr);
      logic [1:0] idx;
      logic       found;
      rr_pick = ptr;
      found   = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         idx = ptr + 2'(i);
         if (!found && req[idx]) begin
            rr_pick = idx;
            found   = 1'b1;
         end
      end
   endfunction

endpackage

// File: rtl/mux41_w.sv
// Combinational DATA_W-wide 4:1 mux.
// Ports:
//   din0..din3 : data inputs
//   sel        : index of the input routed to dout
//   dout       : selected data
module mux41_w #(
   parameter int unsigned DATA_W = 8
) (
   input  logic [DATA_W-1:0] din0,
   input  logic [DATA_W-1:0] din1,
   input  logic [DATA_W-1:0] din2,
   input  logic [DATA_W-1:0] din3,
   input  logic [1:0]        sel,
   output logic [DATA_W-1:0] dout
);

   always_comb begin
      dout = din0;
      unique case (sel)
         2'd0: dout = din0;
         2'd1: dout = din1;
         2'd2: dout = din2;
         2'd3: dout = din3;
      endcase
   end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 data mux between four requesters.
// Each grant lasts at most MAX_BURST accepted beats; one idle cycle separates grants.
// Ports:
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   req        : per-requester request
//   din0..din3 : requester data
//   ready      : downstream accepts dout this cycle
//   gnt        : registered one-hot grant, zero when idle
//   sel        : registered mux select (index of the granted requester)
//   dout       : din[sel], combinational
//   dout_valid : granted and the granted requester still requests
module mux4_rr_arbiter
   import mux4_rr_arbiter_pkg::*;
#(
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned MAX_BURST = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [3:0]        req,
   input  logic [DATA_W-1:0] din0,
   input  logic [DATA_W-1:0] din1,
   input  logic [DATA_W-1:0] din2,
   input  logic [DATA_W-1:0] din3,
   input  logic              ready,
   output logic [3:0]        gnt,
   output logic [1:0]        sel,
   output logic [DATA_W-1:0] dout,
   output logic              dout_valid
);

   localparam int unsigned     CntW    = $clog2(MAX_BURST + 1);
   localparam logic [CntW-1:0] CntLast = CntW'(MAX_BURST - 1);

   arb_state_e      state_q, state_d;
   logic [3:0]      gnt_q, gnt_d;
   logic [1:0]      sel_q, sel_d;
   logic [1:0]      ptr_q, ptr_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [1:0]      winner;
   logic            beat;
   logic            release_burst;

   assign dout_valid = (state_q == StGrant) && req[sel_q];
   assign beat       = dout_valid && ready;
   assign winner     = rr_pick(req, ptr_q);

   // A dropped request can never coincide with a beat, since a beat needs the request.
   assign release_burst = (state_q == StGrant) &&
                          (!req[sel_q] || (beat && (cnt_q == CntLast)));

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      sel_d   = sel_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (req != 4'b0000) begin
               state_d        = StGrant;
               gnt_d          = 4'b0000;
               gnt_d[winner]  = 1'b1;
               sel_d          = winner;
               cnt_d          = '0;
            end
         end
         StGrant: begin
            if (release_burst) begin
               state_d = StIdle;
               gnt_d   = 4'b0000;
               ptr_d   = sel_q + 2'd1;
               cnt_d   = '0;
            end else if (beat) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         gnt_q   <= 4'b0000;
         sel_q   <= 2'd0;
         ptr_q   <= 2'd0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         sel_q   <= sel_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
      end
   end

   assign gnt = gnt_q;
   assign sel = sel_q;

   mux41_w #(
      .DATA_W(DATA_W)
   ) u_mux (
      .din0(din0),
      .din1(din1),
      .din2(din2),
      .din3(din3),
      .sel (sel_q),
      .dout(dout)
   );

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: directed vector table, corner sequences, then random
// traffic checked against a transaction-level reference model.
module tb_mux4_rr_arbiter;

   localparam int DATA_W    = 8;
   localparam int MAX_BURST = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic [3:0]        req;
   logic              ready;
   logic [DATA_W-1:0] din_a [4];
   logic [3:0]        gnt;
   logic [1:0]        sel;
   logic [DATA_W-1:0] dout;
   logic              dout_valid;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   mux4_rr_arbiter #(
      .DATA_W   (DATA_W),
      .MAX_BURST(MAX_BURST)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .din0      (din_a[0]),
      .din1      (din_a[1]),
      .din2      (din_a[2]),
      .din3      (din_a[3]),
      .ready     (ready),
      .gnt       (gnt),
      .sel       (sel),
      .dout      (dout),
      .dout_valid(dout_valid)
   );

   // Reference model: who owns the mux, how many beats it has moved, who is next.
   bit m_busy;
   int m_owner;
   int m_beats;
   int m_ptr;
   int m_sel;
   bit last_beat;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_busy  = 0;
      m_owner = 0;
      m_beats = 0;
      m_ptr   = 0;
      m_sel   = 0;
   endtask

   // Called at a negedge: apply inputs, compare against the model, advance one clock.
   task automatic step(input logic r, input logic [3:0] rq, input logic rdy);
      logic [3:0] exp_gnt;
      bit         exp_valid;
      rst   = r;
      req   = rq;
      ready = rdy;
      #1;
      exp_gnt   = m_busy ? (4'b0001 << m_owner) : 4'b0000;
      exp_valid = m_busy && rq[m_owner];
      check("gnt", 32'(gnt), 32'(exp_gnt));
      check("sel", 32'(sel), 32'(m_sel));
      check("dout_valid", 32'(dout_valid), 32'(exp_valid));
      check("dout", 32'(dout), 32'(din_a[m_sel]));
      last_beat = dout_valid && ready;
      @(posedge clk);
      if (r) begin
         model_reset();
      end else if (!m_busy) begin
         if (rq != 4'b0000) begin
            for (int k = 0; k < 4; k++) begin
               if (!m_busy && rq[(m_ptr + k) % 4]) begin
                  m_busy  = 1;
                  m_owner = (m_ptr + k) % 4;
                  m_sel   = m_owner;
                  m_beats = 0;
               end
            end
         end
      end else begin
         if (!rq[m_owner]) begin
            m_busy = 0;
            m_ptr  = (m_owner + 1) % 4;
         end else if (rdy) begin
            m_beats++;
            if (m_beats == MAX_BURST) begin
               m_busy = 0;
               m_ptr  = (m_owner + 1) % 4;
            end
         end
      end
      @(negedge clk);
   endtask

   typedef struct {
      logic       rst;
      logic [3:0] req;
      logic       ready;
      logic [3:0] gnt;
      logic [1:0] sel;
      logic       valid;
      logic [7:0] dout;
   } vec_t;

   vec_t vecs[$];

   function automatic logic [7:0] din_of(input int i);
      case (i)
         0: return 8'h11;
         1: return 8'h22;
         2: return 8'hA5;
         default: return 8'h3C;
      endcase
   endfunction

   function automatic void add(input logic r, input logic [3:0] rq, input logic [3:0] g,
                               input int s, input logic v);
      vec_t e;
      e.rst   = r;
      e.req   = rq;
      e.ready = 1'b1;
      e.gnt   = g;
      e.sel   = 2'(s);
      e.valid = v;
      e.dout  = din_of(s);
      vecs.push_back(e);
   endfunction

   function automatic void add_burst(input logic [3:0] rq, input int owner);
      for (int b = 0; b < MAX_BURST; b++) add(1'b0, rq, 4'b0001 << owner, owner, 1'b1);
   endfunction

   int beats;

   initial begin
      for (int i = 0; i < 4; i++) din_a[i] = din_of(i);
      rst   = 1'b1;
      req   = 4'b1111;
      ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      model_reset();

      // Reset held, then round robin 0,1,2,3,0, then a lone requester 2 granted twice.
      add(1'b1, 4'b1111, 4'b0000, 0, 1'b0);
      add(1'b1, 4'b1111, 4'b0000, 0, 1'b0);
      add(1'b0, 4'b1111, 4'b0000, 0, 1'b0);
      add_burst(4'b1111, 0);
      add(1'b0, 4'b1111, 4'b0000, 0, 1'b0);
      add_burst(4'b1111, 1);
      add(1'b0, 4'b1111, 4'b0000, 1, 1'b0);
      add_burst(4'b1111, 2);
      add(1'b0, 4'b1111, 4'b0000, 2, 1'b0);
      add_burst(4'b1111, 3);
      add(1'b0, 4'b1111, 4'b0000, 3, 1'b0);
      add_burst(4'b1111, 0);
      add(1'b0, 4'b0100, 4'b0000, 0, 1'b0);
      add_burst(4'b0100, 2);
      add(1'b0, 4'b0100, 4'b0000, 2, 1'b0);
      add_burst(4'b0100, 2);
      add(1'b0, 4'b0000, 4'b0000, 2, 1'b0);

      foreach (vecs[i]) begin
         rst   = vecs[i].rst;
         req   = vecs[i].req;
         ready = vecs[i].ready;
         #1;
         check("vec_gnt", 32'(gnt), 32'(vecs[i].gnt));
         check("vec_sel", 32'(sel), 32'(vecs[i].sel));
         check("vec_valid", 32'(dout_valid), 32'(vecs[i].valid));
         check("vec_dout", 32'(dout), 32'(vecs[i].dout));
         #1;
         step(vecs[i].rst, vecs[i].req, vecs[i].ready);
      end

      // Backpressure: stalls hold the grant, burst still ends after exactly 4 beats.
      step(1'b0, 4'b0001, 1'b1);
      beats = 0;
      step(1'b0, 4'b0001, 1'b1);
      beats += int'(last_beat);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 4'b0001, 1'b0);
         beats += int'(last_beat);
         check("stall_gnt", 32'(gnt), 32'h1);
      end
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 4'b0001, 1'b1);
         beats += int'(last_beat);
      end
      check("stall_beats", 32'(beats), 32'(MAX_BURST));
      check("stall_release", 32'(gnt), 32'h0);

      // Early drop: requester 1 leaves after 2 beats, requester 3 wins next.
      step(1'b0, 4'b1010, 1'b1);
      check("drop_first_gnt", 32'(gnt), 32'h2);
      step(1'b0, 4'b1010, 1'b1);
      step(1'b0, 4'b1010, 1'b1);
      check("drop_hold_gnt", 32'(gnt), 32'h2);
      step(1'b0, 4'b1000, 1'b1);
      check("drop_idle_gnt", 32'(gnt), 32'h0);
      step(1'b0, 4'b1000, 1'b1);
      check("drop_next_gnt", 32'(gnt), 32'h8);
      check("drop_next_sel", 32'(sel), 32'h3);
      step(1'b0, 4'b0000, 1'b1);
      step(1'b0, 4'b0000, 1'b1);

      // Mid-burst reset: pointer returns to 0 so requester 0 wins afterwards.
      step(1'b0, 4'b0001, 1'b1);
      step(1'b0, 4'b0000, 1'b1);
      step(1'b0, 4'b1111, 1'b1);
      check("rst_pre_gnt", 32'(gnt), 32'h2);
      step(1'b0, 4'b1111, 1'b1);
      step(1'b1, 4'b1111, 1'b1);
      check("rst_gnt", 32'(gnt), 32'h0);
      check("rst_sel", 32'(sel), 32'h0);
      check("rst_valid", 32'(dout_valid), 32'h0);
      step(1'b0, 4'b1111, 1'b1);
      check("rst_regrant", 32'(gnt), 32'h1);

      // Random traffic against the model.
      for (int c = 0; c < 3000; c++) begin
         logic [3:0] rq;
         for (int i = 0; i < 4; i++) din_a[i] = 8'($urandom);
         rq = 4'($urandom);
         if ($urandom_range(0, 3) == 0) rq = 4'b0000;
         step(($urandom_range(0, 99) == 0), rq, ($urandom_range(0, 3) != 0));
         check("onehot", 32'($countones(gnt) <= 1), 32'h1);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
